// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration-chain writer.
// The readback sentinel is only shifted when CFG_CHAIN_READBACK_EN is defined.
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CFG_SENTINEL   = 8'hA5;
  localparam int         CFG_SENTINEL_W = 8;

  function automatic int calc_nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Number of bits actually shifted out of the final word of a load.
  function automatic int calc_last_bits(input int chain_len, input int word_w);
    return chain_len - (calc_nwords(chain_len, word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word load/shift buffer. A load consumes bit 0 immediately (the caller
// emits it), so bit_out always shows the next bit still to be shifted.
module cfg_word_serializer
  import cfg_chain_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              empty
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              empty_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      empty_reg <= 1'b1;
    end else if (load) begin
      shreg_reg <= data >> 1;
      cnt_reg   <= CNT_W'(1);
      empty_reg <= (WORD_W == 1);
    end else if (shift && !empty_reg) begin
      shreg_reg <= shreg_reg >> 1;
      cnt_reg   <= cnt_reg + 1'b1;
      empty_reg <= ((cnt_reg + 1'b1) == CNT_W'(WORD_W));
    end
  end

  assign bit_out = shreg_reg[0];
  assign empty   = empty_reg;

endmodule

// File: rtl/cfg_chain_writer.sv
// Serialises configuration words LSB-first into one ccff chain segment.
// Define CFG_CHAIN_READBACK_EN to prepend the 8'hA5 sentinel and check it at the tail.
module cfg_chain_writer
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 50,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef CFG_CHAIN_READBACK_EN
  localparam int SENT_LEN = CFG_SENTINEL_W;
`else
  localparam int SENT_LEN = 0;
`endif
  localparam int CNT_W = $clog2(CHAIN_LEN + 9);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(CHAIN_LEN + SENT_LEN);

  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             ready_reg;
  logic             head_reg;
  logic             en_reg;
  logic             busy_reg;
  logic             done_reg;

  logic ser_clear, ser_load, ser_shift, ser_bit, ser_empty;
  logic sent_phase, sent_bit;

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk     (prog_clk),
    .srst    (pReset),
    .clear   (ser_clear),
    .load    (ser_load),
    .shift   (ser_shift),
    .data    (word_in),
    .bit_out (ser_bit),
    .empty   (ser_empty)
  );

`ifdef CFG_CHAIN_READBACK_EN
  logic       err_reg;
  logic       chk_active;
  logic [2:0] chk_idx;
  logic       mismatch;

  assign sent_phase = (bit_cnt_reg < CNT_W'(SENT_LEN));
  assign sent_bit   = CFG_SENTINEL[bit_cnt_reg[2:0]];
  // bit_cnt already includes the shift on ccff_head this cycle, so the
  // sentinel reaches the tail while bit_cnt is CHAIN_LEN+1..CHAIN_LEN+8.
  assign chk_active = en_reg && (bit_cnt_reg >= CNT_W'(CHAIN_LEN + 1)) &&
                      (bit_cnt_reg <= CNT_W'(CHAIN_LEN + SENT_LEN));
  assign chk_idx    = 3'(bit_cnt_reg - CNT_W'(CHAIN_LEN + 1));
  assign mismatch   = chk_active && (ccff_tail != CFG_SENTINEL[chk_idx]);
  assign err        = err_reg;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign sent_phase  = 1'b0;
  assign sent_bit    = 1'b0;
  assign err         = 1'b0;
`endif

  assign ser_clear = (state_reg == IDLE) && start;
  assign ser_load  = (state_reg == FETCH) && word_valid && ready_reg;
  assign ser_shift = (state_reg == SHIFT) && (bit_cnt_reg != TOTAL_C) &&
                     !sent_phase && !ser_empty;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      ready_reg   <= 1'b0;
      head_reg    <= 1'b0;
      en_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          en_reg   <= 1'b0;
          head_reg <= 1'b0;
          if (start) begin
            busy_reg <= 1'b1;
`ifdef CFG_CHAIN_READBACK_EN
            state_reg   <= SHIFT;
            en_reg      <= 1'b1;
            head_reg    <= CFG_SENTINEL[0];
            bit_cnt_reg <= CNT_W'(1);
`else
            state_reg   <= FETCH;
            ready_reg   <= 1'b1;
            bit_cnt_reg <= '0;
`endif
          end
        end
        FETCH: begin
          if (word_valid) begin
            ready_reg   <= 1'b0;
            state_reg   <= SHIFT;
            en_reg      <= 1'b1;
            head_reg    <= word_in[0];
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt_reg == TOTAL_C) begin
            en_reg    <= 1'b0;
            head_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (sent_phase) begin
            en_reg      <= 1'b1;
            head_reg    <= sent_bit;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else if (ser_empty) begin
            en_reg    <= 1'b0;
            head_reg  <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= FETCH;
          end else begin
            en_reg      <= 1'b1;
            head_reg    <= ser_bit;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CFG_CHAIN_READBACK_EN
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      err_reg <= 1'b0;
    end else if (mismatch) begin
      err_reg <= 1'b1;
    end
  end
`endif

  assign word_ready = ready_reg;
  assign ccff_head  = head_reg;
  assign ccff_en    = en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
